rx_lane_deskew: RTL
===================

Name: rx_lane_deskew

Overview:
- Per-lane elastic deskew stage directly upstream of the RX datapath. It consumes per-lane 8b/10b-decoded bytes from the lane receivers and feeds the PIPE receive inputs of the RX block.
- Buffers each lane in a small FIFO and aligns all active lanes on a common COM symbol (K28.5, 8'hBC with K=1).
- Releases lane-aligned byte columns so downstream lane merging sees symbol-aligned lanes.
- Gen1/Gen2 (8b/10b) only. 128b/130b block alignment is out of scope.

Parameters:
- NUM_LANES, 16, number of physical lanes (1..16).
- DEPTH, 8, per-lane FIFO entries (power of 2, >=4).
- MAX_SKEW, 6, max cycles a COM may wait at a lane head for the other lanes (must be < DEPTH).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- lane_data  input  8*NUM_LANES  byte per lane, lane i at [8i+:8]
- lane_datak  input  NUM_LANES  K flag per lane
- lane_valid  input  NUM_LANES  byte valid per lane
- numberOfDetectedLanes  input  5  active lane count; lanes 0..N-1 are active
- deskew_data  output  8*NUM_LANES  aligned byte column
- deskew_datak  output  NUM_LANES  aligned K flags
- deskew_valid  output  NUM_LANES  per-lane valid of the aligned column
- aligned  output  1  high while in ALIGNED state
- skew_error  output  1  one-cycle pulse on alignment failure

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - All FIFOs empty, state HUNT, wait counter 0.
  - deskew_data = 0, deskew_datak = 0, deskew_valid = 0, aligned = 0, skew_error = 0.
  - Reset asserted mid-operation discards all buffered bytes on the next edge.
- Active lane count: N = min(numberOfDetectedLanes, NUM_LANES). With N = 0 the block stays in HUNT and asserts no valid.
- Inactive lanes:
  - Writes are ignored.
  - Their deskew_valid, data and datak outputs are forced to 0.
- FIFO write: on each cycle with lane_valid[i] high and lane i active, the byte and K flag are written to FIFO i.
- FIFO read: a written entry is visible at the head one cycle later. All outputs are registered, so minimum input-to-output latency is 2 cycles.
- Full FIFO:
  - A write to a full FIFO is an overflow unless that FIFO is also popped in the same cycle; a simultaneous write and pop on a full FIFO is legal.
  - Overflow: skew_error pulses, all FIFOs are flushed, state goes to HUNT.
- State HUNT:
  - Each active lane whose head is non-COM pops and discards it.
  - A lane with COM at its head holds.
  - Once any lane holds, the wait counter increments each cycle.
  - All active lanes hold COM at head in the same cycle -> go to ALIGNED; wait counter cleared.
  - Wait counter reaches MAX_SKEW -> skew_error pulse, flush, stay in HUNT.
- State ALIGNED:
  - When every active FIFO is non-empty, all active lanes pop together. The popped column is registered onto deskew_* with deskew_valid[i] = 1 for active lanes.
  - Otherwise no lane pops and deskew_valid = 0 for that cycle.
  - Misalignment: in a popped column, COM present on some active lanes but not all -> skew_error pulse, flush, go to HUNT. That column is not output.
  - numberOfDetectedLanes changes while ALIGNED -> flush, go to HUNT, no error pulse.
- aligned output: registered, high exactly while state is ALIGNED.
- Pointer arithmetic: log2(DEPTH)+1 bit pointers wrap modulo 2*DEPTH. Full = MSBs differ and remaining bits equal.

Optional Feature:
- Macro: RX_DESKEW_STATS_EN.
- With the macro: an extra output realign_count [7:0]. It increments by 1 on each skew_error pulse, saturates at 255, and resets to 0.
- Without the macro: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- N=4, every lane sends BC(K) then 4A,4A,4A on the same cycles -> ALIGNED rises; columns BC/4A/4A/4A out on lanes 0-3, 2 cycles after input; lanes 4-15 valid=0.
- N=4, lane 2 delayed 3 cycles relative to the others -> ALIGNED reached; output columns have COM on all four lanes in the same cycle; no skew_error.
- N=2, lane 1 delayed 7 cycles (MAX_SKEW=6) -> skew_error pulses once 6 cycles after lane 0 COM reaches head; state HUNT; then realigns on the next common COM.
- ALIGNED with N=4, then inject COM on lane 0 only in a column -> skew_error pulse, aligned falls next cycle, that column is suppressed.
- Lane 3 fed continuously while lane 0 stalls, until FIFO 3 (DEPTH=8) overflows -> skew_error, all FIFOs empty, HUNT; assert reset mid-stream -> all outputs 0 next cycle.
- With RX_DESKEW_STATS_EN, force 300 errors -> realign_count = 255.

Source files
------------

// File: rtl/rx_lane_deskew.sv
// -----------------------------------------------------------------------------
// rx_lane_deskew
//   Per-lane elastic deskew stage. Every active lane is buffered in a small
//   FIFO. The block hunts for a column in which all active lane heads carry
//   COM (K28.5, 9'h1BC as {k,data}). It then releases lane-aligned byte
//   columns to the PIPE receive side of the RX datapath.
//
//   Optional build macro: RX_DESKEW_STATS_EN adds realign_count, a saturating
//   count of skew_error pulses.
//
// Ports:
//   clk                    clock
//   reset                  synchronous, active-high reset
//   lane_data[8i+:8]       decoded byte of lane i
//   lane_datak[i]          K flag of lane i
//   lane_valid[i]          byte valid of lane i
//   numberOfDetectedLanes  active lane count N (lanes 0..N-1 active)
//   deskew_data/_datak     aligned byte column (inactive lanes forced to 0)
//   deskew_valid[i]        lane i of the registered column is valid
//   aligned                high while the aligner is locked
//   skew_error             one-cycle pulse on overflow, HUNT timeout or
//                          COM misalignment
//   realign_count          (RX_DESKEW_STATS_EN only) saturating error count
// -----------------------------------------------------------------------------
module rx_lane_deskew #(
  parameter int NUM_LANES = 16,
  parameter int DEPTH     = 8,
  parameter int MAX_SKEW  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_LANES-1:0] lane_data,
  input  logic [NUM_LANES-1:0]   lane_datak,
  input  logic [NUM_LANES-1:0]   lane_valid,
  input  logic [4:0]             numberOfDetectedLanes,
  output logic [8*NUM_LANES-1:0] deskew_data,
  output logic [NUM_LANES-1:0]   deskew_datak,
  output logic [NUM_LANES-1:0]   deskew_valid,
  output logic                   aligned,
  output logic                   skew_error
`ifdef RX_DESKEW_STATS_EN
  ,
  output logic [7:0]             realign_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  // The wait counter only needs to reach MAX_SKEW-1; the error fires there.
  localparam int WW = (MAX_SKEW < 2) ? 1 : $clog2(MAX_SKEW);
  localparam logic [8:0] COM_SYM = 9'h1BC;
  localparam logic [4:0] LANES_5 = 5'(NUM_LANES);

  typedef enum logic {S_HUNT = 1'b0, S_ALIGNED = 1'b1} state_t;

  state_t                       r_state, w_state_next;
  logic [WW-1:0]                r_wait, w_wait_next;
  logic [4:0]                   r_lanes_seen;
  logic [4:0]                   w_num_active;
  logic [NUM_LANES-1:0]         w_active, w_wr, w_empty, w_full, w_head_com, w_pop;
  logic [NUM_LANES-1:0][8:0]    w_head;
  logic                         w_any_active, w_all_com, w_any_hold, w_all_ready;
  logic                         w_overflow, w_lanes_changed, w_state_err;
  logic                         w_err, w_flush, w_emit;
  logic [8*NUM_LANES-1:0]       w_col_data, r_data;
  logic [NUM_LANES-1:0]         w_col_k, r_datak, r_valid;
  logic                         r_skew_error;

  assign w_num_active    = (numberOfDetectedLanes > LANES_5) ? LANES_5 : numberOfDetectedLanes;
  assign w_lanes_changed = (numberOfDetectedLanes != r_lanes_seen);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [8:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;

    assign w_active[gi]   = (5'(gi) < w_num_active);
    assign w_wr[gi]       = lane_valid[gi] && w_active[gi];
    assign w_empty[gi]    = (r_wr_ptr == r_rd_ptr);
    assign w_full[gi]     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                            (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head[gi]     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_com[gi] = !w_empty[gi] && (w_head[gi] == COM_SYM);

    // Inactive lanes hold their column outputs at zero.
    assign w_col_data[8*gi +: 8] = (w_emit && w_active[gi]) ? w_head[gi][7:0] : 8'h00;
    assign w_col_k[gi]           = w_emit && w_active[gi] && w_head[gi][8];

    always_ff @(posedge clk) begin
      if (w_wr[gi] && !w_flush) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {lane_datak[gi], lane_data[8*gi +: 8]};
      end
    end

    // An inactive lane is kept empty so a later lane-count increase never
    // exposes stale bytes.
    always_ff @(posedge clk) begin
      if (reset || w_flush || !w_active[gi]) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr[gi])  r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign w_any_active = |w_active;
  assign w_all_com    = w_any_active && ((w_head_com & w_active) == w_active);
  assign w_any_hold   = |(w_head_com & w_active);
  assign w_all_ready  = w_any_active && ((~w_empty & w_active) == w_active);

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_pop        = '0;
    w_emit       = 1'b0;
    w_state_err  = 1'b0;
    w_err        = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_all_com) begin
          // The COM column itself is released on the locking cycle.
          w_pop        = w_active;
          w_emit       = 1'b1;
          w_state_next = S_ALIGNED;
          w_wait_next  = '0;
        end else begin
          w_pop = w_active & ~w_empty & ~w_head_com;
          if (!w_any_hold) begin
            w_wait_next = '0;
          end else if (r_wait == WW'(MAX_SKEW - 1)) begin
            w_state_err = 1'b1;
          end else begin
            w_wait_next = r_wait + 1'b1;
          end
        end
      end
      S_ALIGNED: begin
        if (w_all_ready) begin
          w_pop = w_active;
          if (w_any_hold && !w_all_com) w_state_err = 1'b1;
          else                          w_emit      = 1'b1;
        end
      end
      default: w_state_next = S_HUNT;
    endcase

    // A write to a full FIFO is only safe when that FIFO pops this cycle.
    w_overflow = |(w_wr & w_full & ~w_pop);

    if (w_overflow) begin
      w_err   = 1'b1;
      w_flush = 1'b1;
    end else if (r_state == S_ALIGNED && w_lanes_changed) begin
      w_flush = 1'b1;
    end else if (w_state_err) begin
      w_err   = 1'b1;
      w_flush = 1'b1;
    end

    if (w_flush) begin
      w_emit       = 1'b0;
      w_state_next = S_HUNT;
      w_wait_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_HUNT;
      r_wait       <= '0;
      r_lanes_seen <= '0;
      r_data       <= '0;
      r_datak      <= '0;
      r_valid      <= '0;
      r_skew_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wait       <= w_wait_next;
      r_lanes_seen <= numberOfDetectedLanes;
      r_data       <= w_col_data;
      r_datak      <= w_col_k;
      r_valid      <= w_emit ? w_active : '0;
      r_skew_error <= w_err;
    end
  end

  assign deskew_data  = r_data;
  assign deskew_datak = r_datak;
  assign deskew_valid = r_valid;
  assign aligned      = (r_state == S_ALIGNED);
  assign skew_error   = r_skew_error;

`ifdef RX_DESKEW_STATS_EN
  logic [7:0] r_realign_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_realign_count <= '0;
    end else if (w_err && r_realign_count != 8'hFF) begin
      r_realign_count <= r_realign_count + 8'd1;
    end
  end
  assign realign_count = r_realign_count;
`endif

endmodule
